// File: rtl/pll_lock_seq_pkg.sv
// Shared types and constants for the PLL lock sequencer.
// The optional lock watchdog is enabled by defining PLL_LOCK_SEQ_WATCHDOG_EN.
package pll_lock_seq_pkg;

   // Sequencer states: hold PLL in reset, wait for lock, qualify lock, run.
   typedef enum logic [1:0] {
      S_PLLRST = 2'd0,
      S_WAIT   = 2'd1,
      S_STABLE = 2'd2,
      S_RUN    = 2'd3
   } state_t;

   // Width of the watchdog retry counter and its saturation value.
   localparam int unsigned RETRY_W = 4;
   localparam logic [RETRY_W-1:0] RETRY_MAX = '1;

   // Largest of three cycle counts; used to size the shared state counter.
   function automatic int unsigned max3(input int unsigned a,
                                        input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

   // Counter width able to hold 0 .. max_cycles-1 (never less than one bit).
   function automatic int unsigned cnt_width(input int unsigned max_cycles);
      return (max_cycles < 2) ? 1 : $clog2(max_cycles);
   endfunction

endpackage

// File: rtl/pll_lock_seq_sync.sv
// Two-flop synchronizer for a single asynchronous level signal.
// Reset clears both stages so the synchronized output starts low.
module sync_2ff (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   // Shift the asynchronous input through two flops clocked by clk_i.
   always_ff @(posedge clk_i) begin
      // NOTE: non-blocking assignments make both stages sample the old values,
      // which is what turns these two statements into a two-flop shift chain.
      if (rst_i) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_seq.sv
// PLL lock sequencer: pulses the PLL reset, waits for a synchronized lock,
// qualifies it for STABLE_CYCLES, then releases the core reset. Lock loss
// while running restarts the sequence and emits a one-cycle lock_lost pulse.
// Optional feature macro: PLL_LOCK_SEQ_WATCHDOG_EN (lock timeout + retries).
module pll_lock_seq
   import pll_lock_seq_pkg::*;
#(
   parameter int unsigned RST_CYCLES    = 16,
   parameter int unsigned LOCK_TIMEOUT  = 1048576,
   parameter int unsigned STABLE_CYCLES = 4096
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               pll_locked,
   input  logic               relock_req,
   output logic               pll_rst,
   output logic               core_rst,
   output logic               ready,
   output logic               lock_lost,
   output logic [RETRY_W-1:0] retry_cnt
);

`ifdef PLL_LOCK_SEQ_WATCHDOG_EN
   localparam int unsigned MAX_CYC = max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
`else
   localparam int unsigned MAX_CYC = max3(RST_CYCLES, STABLE_CYCLES, 0);
`endif
   localparam int unsigned CNT_W = cnt_width(MAX_CYC);

   // Terminal counts: the counter reads N-1 on the last cycle of an N-cycle dwell.
   localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
`ifdef PLL_LOCK_SEQ_WATCHDOG_EN
   localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
`endif

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             cnt_run;
   logic             locked_s;
   logic             lost_ev;

   logic pll_rst_q,   pll_rst_d;
   logic core_rst_q,  core_rst_d;
   logic ready_q,     ready_d;
   logic lock_lost_q, lock_lost_d;

`ifdef PLL_LOCK_SEQ_WATCHDOG_EN
   logic               timeout_ev;
   logic [RETRY_W-1:0] retry_q, retry_d;
`else
   // The timeout is meaningless without the watchdog; keep the parameter referenced.
   logic unused_lock_timeout;
   assign unused_lock_timeout = (LOCK_TIMEOUT != 0);
`endif

   sync_2ff u_lock_sync (
      .clk_i (clk),
      .rst_i (rst),
      .d_i   (pll_locked),
      .q_o   (locked_s)
   );

   // State register and shared dwell counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_PLLRST;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state and counter: relock_req outranks every lock or timeout event.
   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves it
      // unassigned; an unassigned path in combinational logic infers a latch.
      state_d = state_q;
      lost_ev = 1'b0;
`ifdef PLL_LOCK_SEQ_WATCHDOG_EN
      timeout_ev = 1'b0;
`endif
      if (relock_req) begin
         state_d = S_PLLRST;
      end else begin
         unique case (state_q)
            S_PLLRST: begin
               if (cnt_q == RST_LAST) state_d = S_WAIT;
            end
            S_WAIT: begin
               if (locked_s) begin
                  state_d = S_STABLE;
               end
`ifdef PLL_LOCK_SEQ_WATCHDOG_EN
               else if (cnt_q == LOCK_LAST) begin
                  state_d    = S_PLLRST;
                  timeout_ev = 1'b1;
               end
`endif
            end
            S_STABLE: begin
               if (!locked_s)                state_d = S_WAIT;
               else if (cnt_q == STABLE_LAST) state_d = S_RUN;
            end
            S_RUN: begin
               if (!locked_s) begin
                  state_d = S_PLLRST;
                  lost_ev = 1'b1;
               end
            end
            default: state_d = S_PLLRST;
         endcase
      end

      // Only states with a timed exit advance the counter; others hold it.
      cnt_run = (state_q == S_PLLRST) || (state_q == S_STABLE);
`ifdef PLL_LOCK_SEQ_WATCHDOG_EN
      if (state_q == S_WAIT) cnt_run = 1'b1;
`endif
      if (relock_req || (state_d != state_q)) cnt_d = '0;
      else if (cnt_run)                       cnt_d = cnt_q + 1'b1;
      else                                    cnt_d = cnt_q;
   end

   // Output decode from the next state so registered outputs move with the state.
   always_comb begin
      pll_rst_d   = (state_d == S_PLLRST);
      core_rst_d  = (state_d != S_RUN);
      ready_d     = (state_d == S_RUN);
      lock_lost_d = lost_ev;
`ifdef PLL_LOCK_SEQ_WATCHDOG_EN
      retry_d = retry_q;
      if (timeout_ev && (retry_q != RETRY_MAX)) retry_d = retry_q + 1'b1;
`endif
   end

   // Output registers; reset puts the PLL and the core into reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         pll_rst_q   <= 1'b1;
         core_rst_q  <= 1'b1;
         ready_q     <= 1'b0;
         lock_lost_q <= 1'b0;
`ifdef PLL_LOCK_SEQ_WATCHDOG_EN
         retry_q     <= '0;
`endif
      end else begin
         pll_rst_q   <= pll_rst_d;
         core_rst_q  <= core_rst_d;
         ready_q     <= ready_d;
         lock_lost_q <= lock_lost_d;
`ifdef PLL_LOCK_SEQ_WATCHDOG_EN
         retry_q     <= retry_d;
`endif
      end
   end

   assign pll_rst   = pll_rst_q;
   assign core_rst  = core_rst_q;
   assign ready     = ready_q;
   assign lock_lost = lock_lost_q;
`ifdef PLL_LOCK_SEQ_WATCHDOG_EN
   assign retry_cnt = retry_q;
`else
   assign retry_cnt = '0;
`endif

endmodule

// File: tb/tb_pll_lock_seq.sv
// Self-checking bench for pll_lock_seq with RST_CYCLES=4, LOCK_TIMEOUT=32,
// STABLE_CYCLES=8. Directed scenarios followed by randomized lock/relock/reset
// traffic, all compared cycle by cycle against a timestamp-style reference.
module tb_pll_lock_seq;

   localparam int RST_CYC    = 4;
   localparam int LOCK_TO    = 32;
   localparam int STABLE_CYC = 8;
`ifdef PLL_LOCK_SEQ_WATCHDOG_EN
   localparam bit WD = 1'b1;
`else
   localparam bit WD = 1'b0;
`endif

   logic       clk;
   logic       rst;
   logic       pll_locked;
   logic       relock_req;
   logic       pll_rst;
   logic       core_rst;
   logic       ready;
   logic       lock_lost;
   logic [3:0] retry_cnt;

   int n_checks = 0;
   int n_pass   = 0;

   pll_lock_seq #(
      .RST_CYCLES    (RST_CYC),
      .LOCK_TIMEOUT  (LOCK_TO),
      .STABLE_CYCLES (STABLE_CYC)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .pll_locked (pll_locked),
      .relock_req (relock_req),
      .pll_rst    (pll_rst),
      .core_rst   (core_rst),
      .ready      (ready),
      .lock_lost  (lock_lost),
      .retry_cnt  (retry_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
   endtask

   // Reference: which phase of the sequence we are in and how many edges
   // have elapsed since it began; lock is seen through a 2-deep sample delay.
   localparam int P_PULSE = 0, P_WAITING = 1, P_QUALIFY = 2, P_RUNNING = 3;
   int m_phase   = P_PULSE;
   int m_elapsed = 0;
   int m_retry   = 0;
   bit m_lost    = 1'b0;
   bit lock_hist[$] = '{1'b0, 1'b0};

   task automatic model_edge();
      bit seen;
      int nxt;
      bit restart;
      if (rst) begin
         m_phase = P_PULSE; m_elapsed = 0; m_retry = 0; m_lost = 1'b0;
         lock_hist = '{1'b0, 1'b0};
      end else begin
         seen    = lock_hist[0];
         nxt     = m_phase;
         restart = 1'b0;
         m_lost  = 1'b0;
         if (relock_req) begin
            nxt = P_PULSE; restart = 1'b1;
         end else begin
            case (m_phase)
               P_PULSE:   if (m_elapsed + 1 >= RST_CYC) nxt = P_WAITING;
               P_WAITING: if (seen) nxt = P_QUALIFY;
                          else if (WD && m_elapsed + 1 >= LOCK_TO) begin
                             nxt = P_PULSE;
                             m_retry = (m_retry < 15) ? m_retry + 1 : 15;
                          end
               P_QUALIFY: if (!seen) nxt = P_WAITING;
                          else if (m_elapsed + 1 >= STABLE_CYC) nxt = P_RUNNING;
               default:   if (!seen) begin nxt = P_PULSE; m_lost = 1'b1; end
            endcase
         end
         m_elapsed = (restart || nxt != m_phase) ? 0 : m_elapsed + 1;
         m_phase   = nxt;
         void'(lock_hist.pop_front());
         lock_hist.push_back(pll_locked);
      end
   endtask

   // One clock: advance the reference on the edge, compare all outputs after it.
   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check("pll_rst",   pll_rst,   (m_phase == P_PULSE));
      check("core_rst",  core_rst,  (m_phase != P_RUNNING));
      check("ready",     ready,     (m_phase == P_RUNNING));
      check("lock_lost", lock_lost, m_lost);
      check("retry_cnt", retry_cnt, m_retry);
   endtask

   task automatic do_reset();
      rst = 1'b1; relock_req = 1'b0; pll_locked = 1'b0;
      step(); step();
      rst = 1'b0;
   endtask

   task automatic wait_ready(input int budget);
      int k;
      for (k = 0; k < budget && !ready; k++) step();
      if (!ready) check("wait_ready_timeout", 0, 1);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int hi_cnt, last_hi, rise, lost_cnt, r0, rises, prev;
      int hold;

      rst = 1'b1; pll_locked = 1'b0; relock_req = 1'b0;
      step(); step(); step();
      check("reset_pll_rst",   pll_rst,   1);
      check("reset_core_rst",  core_rst,  1);
      check("reset_ready",     ready,     0);
      check("reset_lock_lost", lock_lost, 0);
      check("reset_retry",     retry_cnt, 0);

      // Release reset, raise lock at cycle 10.
      rst = 1'b0; hi_cnt = 0; last_hi = -1;
      for (int c = 0; c < 10; c++) begin
         if (pll_rst) begin hi_cnt++; last_hi = c; end
         step();
      end
      check("pllrst_pulse_len",  hi_cnt,  RST_CYC);
      check("pllrst_pulse_last", last_hi, RST_CYC - 1);
      pll_locked = 1'b1; rise = 0;
      // Edge 1 is the edge that first samples pll_locked high.
      for (int k = 1; k <= 40 && rise == 0; k++) begin
         step();
         if (ready) rise = k;
      end
      check("ready_rise_edge", rise, 11);

      // Lock loss while running.
      pll_locked = 1'b0; lost_cnt = 0; hi_cnt = 0;
      for (int k = 0; k < 20; k++) begin
         step();
         if (lock_lost) begin
            lost_cnt++;
            check("lost_core_rst", core_rst, 1);
            check("lost_pll_rst",  pll_rst,  1);
         end
         if (pll_rst) hi_cnt++;
      end
      check("lost_pulses",       lost_cnt, 1);
      check("lost_pllrst_len",   hi_cnt,   RST_CYC);

      // relock_req coincident with lock loss in the running state.
      pll_locked = 1'b1;
      wait_ready(60);
      r0 = retry_cnt;
      pll_locked = 1'b0;
      step(); step();
      relock_req = 1'b1;
      step();
      relock_req = 1'b0;
      check("relock_lost_zero", lock_lost, 0);
      check("relock_pll_rst",   pll_rst,   1);
      check("relock_retry",     retry_cnt, r0);

      // One-cycle lock dropout during qualification delays ready.
      pll_locked = 1'b1;
      wait_ready(60);
      r0 = retry_cnt;
      relock_req = 1'b1; step(); relock_req = 1'b0;
      for (int k = 0; k < 40 && !(m_phase == P_QUALIFY && m_elapsed == 3); k++) step();
      check("reach_qualify", (m_phase == P_QUALIFY && m_elapsed == 3), 1);
      pll_locked = 1'b0; step(); pll_locked = 1'b1;
      rise = 0;
      for (int k = 1; k <= 60 && rise == 0; k++) begin
         step();
         if (ready) rise = k;
      end
      // Undisturbed, ready would follow 4 more qualifying edges.
      check("glitch_delays_ready", (rise > 4), 1);
      check("glitch_retry",        retry_cnt, r0);

      // Lock never arrives.
      do_reset();
      rises = 0; prev = pll_rst; hi_cnt = 0;
      if (WD) begin
         for (int c = 1; c <= 36 * 17 - 2; c++) begin
            step();
            if (pll_rst && !prev) begin
               rises++;
               check("wd_period", c, 36 * rises);
               check("wd_retry_seq", retry_cnt, (rises < 15) ? rises : 15);
            end
            prev = pll_rst;
         end
         check("wd_rises", rises, 16);
         check("wd_retry_sat", retry_cnt, 15);
      end else begin
         for (int c = 0; c < 1000; c++) begin
            if (pll_rst) hi_cnt++;
            step();
            if (pll_rst && !prev) rises++;
            prev = pll_rst;
         end
         check("nowd_rises",   rises,     0);
         check("nowd_pll_len", hi_cnt,    RST_CYC);
         check("nowd_retry",   retry_cnt, 0);
      end

      // Randomized traffic: lock toggles with mixed hold times, sporadic
      // relock requests and occasional mid-sequence resets.
      do_reset();
      hold = 0;
      for (int c = 0; c < 4000; c++) begin
         if (hold == 0) begin
            pll_locked = ~pll_locked;
            hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(5, 60);
         end
         hold--;
         relock_req = ($urandom_range(0, 63) == 0);
         rst        = ($urandom_range(0, 499) == 0);
         step();
      end
      rst = 1'b0; relock_req = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
